bmp_blitter: RTL and testbench
==============================

BMP_BLITTER -- requirements
Module: bmp_blitter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  SCR_W 640 screen width, pixels
  SCR_H 480 screen height, pixels
  PIX_W 9 pixel width, bits
  ROM_AW 16 image ROM address width
  N_IMG 32 selectable images
  TRANSP 9'h088 transparent pixel key
  FONT_W 13 glyph width
  FONT_H 16 glyph height
  FONT_SHEET_W 546 font sheet row pitch
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk in 1 clock
  rst_n in 1 asynchronous active-low reset
  cmd_vld in 1 command valid
  cmd_rdy out 1 command accepted when vld&rdy
  cmd_op in 2 00 add image, 01 remove image, 10 add glyph, 11 reserved
  cmd_indx in 6 image index (low log2(N_IMG) bits) or glyph index
  cmd_x in clog2(SCR_W) left column; cmd_y in clog2(SCR_H) top row
  rom_sel out clog2(N_IMG) image ROM select; rom_font out 1 selects font ROM
  rom_addr out ROM_AW ROM word address, registered
  rom_rdata in PIX_W synchronous ROM data, valid the cycle after rom_addr
  waddr out clog2(SCR_W*SCR_H) linear videoMem address (y*SCR_W+x)
  wdata out PIX_W pixel to write; we out 1 write strobe
  busy out 1 command in progress; done out 1 one-cycle completion pulse
REQ-003 Reset rst_n asynchronous, active-low; clock clk; all flops on posedge clk.

Function
REQ-004 States IDLE, RD_W, RD_H, DRAW, FLUSH; cmd_rdy=1 only in IDLE; busy=!cmd_rdy.
REQ-005 Op 11 accepted and discarded: done pulses next cycle, no writes.
REQ-006 Image layout: word0 = width, word1 = height (both 10b), then pixels row-major from word2.
REQ-007 Image accept in cycle T: rom_addr=0 at T+1, width captured T+2, height T+3, pixel(0,0) write (we) at T+5.
REQ-008 Glyph n: pixel (c,r) at font address r*FONT_SHEET_W + n*FONT_W + c; first write at T+3.
REQ-009 DRAW issues one ROM address per cycle, rows back-to-back with no bubble; waddr/wdata/we registered, aligned via one pipeline stage.
REQ-010 Pixel equal to TRANSP: we=0 for that cycle, traversal continues.
REQ-011 Remove: wdata=0 at every non-transparent pixel position of the image.
REQ-012 Clipping: pixel with cmd_x+c >= SCR_W or cmd_y+r >= SCR_H gets we=0; no address wrap onto next row/frame.
REQ-013 Width or height 0: no writes; done at T+4.
REQ-014 FLUSH covers the last pipelined write; done pulses the cycle after the final write slot; IDLE follows.
REQ-015 cmd_indx >= N_IMG for image ops: treated as zero-size (REQ-013 timing).
REQ-016 Arithmetic: address math at full width, no truncation before compare; wdata is don't-care-free (0) when we=0.

Reset
REQ-017 Reset, including mid-command: state IDLE, we=0, done=0, busy=0, waddr=0, wdata=0, rom_addr=0, counters 0; command discarded.
REQ-018 First command accepted in the first cycle after rst_n deasserts.

Structure
REQ-019 Package blit_pkg holds op enum, state enum, default parameter constants.
REQ-020 Sub-module blit_addr_gen: column/row counters, ROM address and screen address generation, clip flag.

Verification
REQ-021 3x2 image idx 1 at (10,5), pixels 1..6 -> waddr 3210,3211,3212,3850,3851,3852, data 1..6, first we T+5, done once.
REQ-022 Same image with pixel 3 = 9'h088 -> 5 writes, 3212 skipped, timing unchanged.
REQ-023 Same image at (639,479) -> single write waddr 307199; done at same cycle as unclipped case.
REQ-024 Glyph 2 at (0,0) -> 208 writes, first rom_addr 26, rows stepped by 546, first we T+3.
REQ-025 Remove image idx 1 at (10,5) -> six writes of 0 at REQ-021 addresses.
REQ-026 rst_n low during DRAW then new command -> we drops immediately, no done, new command runs normally.

Source files
------------

// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared op/state encodings and default geometry for the blitter
package blit_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_REM   = 2'b01,
        OP_GLYPH = 2'b10,
        OP_RSVD  = 2'b11
    } blit_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_W  = 3'd1,
        ST_RD_H  = 3'd2,
        ST_DRAW  = 3'd3,
        ST_FLUSH = 3'd4
    } blit_state_e;

    localparam int DEF_SCR_W        = 640;
    localparam int DEF_SCR_H        = 480;
    localparam int DEF_PIX_W        = 9;
    localparam int DEF_ROM_AW       = 16;
    localparam int DEF_N_IMG        = 32;
    localparam int DEF_TRANSP       = 'h088;
    localparam int DEF_FONT_W       = 13;
    localparam int DEF_FONT_H       = 16;
    localparam int DEF_FONT_SHEET_W = 546;

    // image header words carry 10-bit width/height
    localparam int DIM_W = 10;

endpackage

// File: rtl/bmp_blitter_if.sv
// rtl/bmp_blitter_if.sv - command, ROM and video-memory write bundle of the blitter
interface bmp_blitter_if #(
    parameter int SCR_W  = blit_pkg::DEF_SCR_W,
    parameter int SCR_H  = blit_pkg::DEF_SCR_H,
    parameter int PIX_W  = blit_pkg::DEF_PIX_W,
    parameter int ROM_AW = blit_pkg::DEF_ROM_AW,
    parameter int N_IMG  = blit_pkg::DEF_N_IMG
);
    localparam int XW   = $clog2(SCR_W);
    localparam int YW   = $clog2(SCR_H);
    localparam int SELW = $clog2(N_IMG);
    localparam int SAW  = $clog2(SCR_W * SCR_H);

    logic              cmd_vld;
    logic              cmd_rdy;
    logic [1:0]        cmd_op;
    logic [5:0]        cmd_indx;
    logic [XW-1:0]     cmd_x;
    logic [YW-1:0]     cmd_y;
    logic [SELW-1:0]   rom_sel;
    logic              rom_font;
    logic [ROM_AW-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_rdata;
    logic [SAW-1:0]    waddr;
    logic [PIX_W-1:0]  wdata;
    logic              we;
    logic              busy;
    logic              done;

    modport master (
        output cmd_vld, cmd_op, cmd_indx, cmd_x, cmd_y, rom_rdata,
        input  cmd_rdy, rom_sel, rom_font, rom_addr, waddr, wdata, we, busy, done
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_indx, cmd_x, cmd_y, rom_rdata,
        output cmd_rdy, rom_sel, rom_font, rom_addr, waddr, wdata, we, busy, done
    );

endinterface

// File: rtl/blit_addr_gen.sv
// rtl/blit_addr_gen.sv - column/row traversal, ROM address, screen address and clip flag
module blit_addr_gen
    import blit_pkg::*;
#(
    parameter int SCR_W        = DEF_SCR_W,
    parameter int SCR_H        = DEF_SCR_H,
    parameter int ROM_AW       = DEF_ROM_AW,
    parameter int FONT_W       = DEF_FONT_W,
    parameter int FONT_SHEET_W = DEF_FONT_SHEET_W,
    localparam int XW          = $clog2(SCR_W),
    localparam int YW          = $clog2(SCR_H),
    localparam int SAW         = $clog2(SCR_W * SCR_H)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_img,
    input  logic              load_glyph,
    input  logic              hdr_step,
    input  logic              step,
    input  logic              glyph,
    input  logic [5:0]        glyph_indx,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [DIM_W-1:0]  w,
    input  logic [DIM_W-1:0]  h,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              last,
    output logic [SAW-1:0]    scr_addr,
    output logic              clip
);

    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic [DIM_W:0]    col_n;
    logic [DIM_W:0]    row_n;
    logic [ROM_AW-1:0] row_base;
    logic [ROM_AW-1:0] pitch;
    logic [ROM_AW-1:0] glyph_base;
    logic              col_last;
    logic              row_last;
    logic [31:0]       sx;
    logic [31:0]       sy;

    assign col_n    = {1'b0, col} + {{DIM_W{1'b0}}, 1'b1};
    assign row_n    = {1'b0, row} + {{DIM_W{1'b0}}, 1'b1};
    assign col_last = (col_n == {1'b0, w});
    assign row_last = (row_n == {1'b0, h});
    assign last     = col_last && row_last;

    // images are stored contiguously; glyphs live in one wide sheet
    assign pitch      = glyph ? ROM_AW'(FONT_SHEET_W) : ROM_AW'(w);
    assign glyph_base = ROM_AW'(glyph_indx) * ROM_AW'(FONT_W);

    // screen coordinates kept wide so off-screen pixels never alias a valid address
    assign sx       = 32'(x) + 32'(col);
    assign sy       = 32'(y) + 32'(row);
    assign clip     = (sx >= 32'(SCR_W)) || (sy >= 32'(SCR_H));
    assign scr_addr = SAW'(sy * 32'(SCR_W) + sx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            row_base <= '0;
        end else if (load_img) begin
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            row_base <= '0;
        end else if (load_glyph) begin
            col      <= '0;
            row      <= '0;
            rom_addr <= glyph_base;
            row_base <= glyph_base;
        end else if (hdr_step) begin
            rom_addr <= rom_addr + ROM_AW'(1);
            row_base <= rom_addr + ROM_AW'(1);
        end else if (step) begin
            if (col_last) begin
                col      <= '0;
                row      <= row_n[DIM_W-1:0];
                rom_addr <= row_base + pitch;
                row_base <= row_base + pitch;
            end else begin
                col      <= col_n[DIM_W-1:0];
                rom_addr <= rom_addr + ROM_AW'(1);
            end
        end
    end

endmodule

// File: rtl/bmp_blitter.sv
// rtl/bmp_blitter.sv - draws/erases ROM images and font glyphs into linear video memory
module bmp_blitter
    import blit_pkg::*;
#(
    parameter int SCR_W                = DEF_SCR_W,
    parameter int SCR_H                = DEF_SCR_H,
    parameter int PIX_W                = DEF_PIX_W,
    parameter int ROM_AW               = DEF_ROM_AW,
    parameter int N_IMG                = DEF_N_IMG,
    parameter logic [PIX_W-1:0] TRANSP = PIX_W'(DEF_TRANSP),
    parameter int FONT_W               = DEF_FONT_W,
    parameter int FONT_H               = DEF_FONT_H,
    parameter int FONT_SHEET_W         = DEF_FONT_SHEET_W
)(
    input logic          clk,
    input logic          rst_n,
    bmp_blitter_if.slave bus
);

    localparam int XW   = $clog2(SCR_W);
    localparam int YW   = $clog2(SCR_H);
    localparam int SELW = $clog2(N_IMG);
    localparam int SAW  = $clog2(SCR_W * SCR_H);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] RD_W  = ST_RD_W;
    localparam logic [2:0] RD_H  = ST_RD_H;
    localparam logic [2:0] DRAW  = ST_DRAW;
    localparam logic [2:0] FLUSH = ST_FLUSH;

    logic [2:0]        state;
    logic [SELW-1:0]   rom_sel_r;
    logic              rom_font_r;
    logic              remove_r;
    logic              bad_r;
    logic              hfirst;
    logic              fl;
    logic [DIM_W-1:0]  w_r;
    logic [DIM_W-1:0]  h_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic              p_vld;
    logic              p_clip;
    logic [SAW-1:0]    p_addr;
    logic [SAW-1:0]    waddr_r;
    logic [PIX_W-1:0]  wdata_r;
    logic              we_r;
    logic              done_r;

    logic              accept;
    logic              is_img;
    logic              zero;
    logic              iss;
    logic              wr;
    logic [DIM_W-1:0]  rd_dim;
    logic [DIM_W-1:0]  w_eff;
    logic [DIM_W-1:0]  h_eff;
    logic [ROM_AW-1:0] rom_addr;
    logic              last;
    logic [SAW-1:0]    scr_addr;
    logic              clip;

    assign accept = bus.cmd_vld && (state == IDLE);
    assign is_img = (bus.cmd_op == OP_ADD) || (bus.cmd_op == OP_REM);
    assign rd_dim = DIM_W'(bus.rom_rdata);

    // height arrives on rom_rdata during the first DRAW cycle, so it is used directly there
    assign zero  = hfirst && ((w_r == '0) || (rd_dim == '0) || bad_r);
    assign iss   = (state == DRAW) && !zero;
    assign w_eff = rom_font_r ? DIM_W'(FONT_W) : w_r;
    assign h_eff = rom_font_r ? DIM_W'(FONT_H) : (hfirst ? rd_dim : h_r);
    assign wr    = p_vld && !p_clip && (bus.rom_rdata != TRANSP);

    blit_addr_gen #(
        .SCR_W        (SCR_W),
        .SCR_H        (SCR_H),
        .ROM_AW       (ROM_AW),
        .FONT_W       (FONT_W),
        .FONT_SHEET_W (FONT_SHEET_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_img   (accept && is_img),
        .load_glyph (accept && (bus.cmd_op == OP_GLYPH)),
        .hdr_step   ((state == RD_W) || (state == RD_H)),
        .step       (iss),
        .glyph      (rom_font_r),
        .glyph_indx (bus.cmd_indx),
        .x          (x_r),
        .y          (y_r),
        .w          (w_eff),
        .h          (h_eff),
        .rom_addr   (rom_addr),
        .last       (last),
        .scr_addr   (scr_addr),
        .clip       (clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_sel_r  <= '0;
            rom_font_r <= 1'b0;
            remove_r   <= 1'b0;
            bad_r      <= 1'b0;
            hfirst     <= 1'b0;
            fl         <= 1'b0;
            w_r        <= '0;
            h_r        <= '0;
            x_r        <= '0;
            y_r        <= '0;
            p_vld      <= 1'b0;
            p_clip     <= 1'b0;
            p_addr     <= '0;
            waddr_r    <= '0;
            wdata_r    <= '0;
            we_r       <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // stage 1 tags line up with rom_rdata one cycle after the address
            p_vld   <= iss;
            p_clip  <= clip;
            p_addr  <= scr_addr;
            we_r    <= wr;
            waddr_r <= wr ? p_addr : '0;
            wdata_r <= wr ? (remove_r ? '0 : bus.rom_rdata) : '0;

            case (state)
                IDLE: begin
                    if (bus.cmd_vld) begin
                        rom_sel_r  <= bus.cmd_indx[SELW-1:0];
                        rom_font_r <= (bus.cmd_op == OP_GLYPH);
                        remove_r   <= (bus.cmd_op == OP_REM);
                        bad_r      <= (32'(bus.cmd_indx) >= 32'(N_IMG));
                        x_r        <= bus.cmd_x;
                        y_r        <= bus.cmd_y;
                        case (bus.cmd_op)
                            OP_ADD, OP_REM: state  <= RD_W;
                            OP_GLYPH:       state  <= DRAW;
                            default:        done_r <= 1'b1;
                        endcase
                    end
                end
                RD_W: state <= RD_H;
                RD_H: begin
                    w_r    <= rd_dim;
                    hfirst <= 1'b1;
                    state  <= DRAW;
                end
                DRAW: begin
                    hfirst <= 1'b0;
                    if (hfirst) begin
                        h_r <= rd_dim;
                    end
                    if (zero) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end else if (last) begin
                        state <= FLUSH;
                        fl    <= 1'b0;
                    end
                end
                FLUSH: begin
                    // one cycle for the ROM read, one for the registered write
                    fl <= 1'b1;
                    if (fl) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_rdy  = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.rom_sel  = rom_sel_r;
    assign bus.rom_font = rom_font_r;
    assign bus.rom_addr = rom_addr;
    assign bus.waddr    = waddr_r;
    assign bus.wdata    = wdata_r;
    assign bus.we       = we_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_bmp_blitter.sv
// tb/tb_bmp_blitter.sv - directed self-checking bench for bmp_blitter
module tb_bmp_blitter;
    import blit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bmp_blitter_if bif ();

    bmp_blitter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] img1 [0:7];
    int wq_cyc[$];
    int wq_addr[$];
    int wq_data[$];
    int dq[$];

    function automatic logic [8:0] font_pix(input logic [15:0] a);
        return (a[8:0] == 9'h088) ? 9'h001 : a[8:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous ROMs: only image 1 has content, all other selects read zero
    always @(posedge clk) begin
        if (bif.rom_font)
            bif.rom_rdata <= font_pix(bif.rom_addr);
        else if (bif.rom_sel == 5'd1 && bif.rom_addr < 16'd8)
            bif.rom_rdata <= img1[bif.rom_addr[2:0]];
        else
            bif.rom_rdata <= 9'd0;
    end

    always @(negedge clk) begin
        if (bif.we) begin
            wq_cyc.push_back(cyc);
            wq_addr.push_back(int'(bif.waddr));
            wq_data.push_back(int'(bif.wdata));
        end
        if (bif.done) dq.push_back(cyc);
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wq_cyc.delete();
        wq_addr.delete();
        wq_data.delete();
        dq.delete();
    endtask

    // call right after a falling edge; the command is taken at the next rising edge
    task automatic issue(input logic [1:0] op, input int idx, input int x, input int y,
                         output int t0, output int ra1);
        check("cmd_rdy_idle", int'(bif.cmd_rdy), 1);
        bif.cmd_vld  = 1'b1;
        bif.cmd_op   = op;
        bif.cmd_indx = 6'(idx);
        bif.cmd_x    = 10'(x);
        bif.cmd_y    = 9'(y);
        t0 = cyc;
        @(negedge clk);
        bif.cmd_vld = 1'b0;
        ra1 = int'(bif.rom_addr);
    endtask

    task automatic wait_done();
        int n = 0;
        while (dq.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_run(input string tag, input int t0, input int n,
                           input int ea[6], input int ed[6],
                           input int first_off, input int done_off);
        check({tag, "_nwr"}, wq_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wq_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), wq_addr[i], ea[i]);
                check($sformatf("%s_data%0d", tag, i), wq_data[i], ed[i]);
            end
        end
        if (n > 0 && wq_cyc.size() > 0)
            check({tag, "_first_we"}, wq_cyc[0], t0 + first_off);
        check({tag, "_ndone"}, dq.size(), 1);
        if (dq.size() > 0)
            check({tag, "_done_cyc"}, dq[0], t0 + done_off);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ra;
        int ea[6];
        int ed[6];

        img1 = '{9'd3, 9'd2, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6};
        rst_n        = 1'b0;
        bif.cmd_vld  = 1'b0;
        bif.cmd_op   = 2'b00;
        bif.cmd_indx = 6'd0;
        bif.cmd_x    = 10'd0;
        bif.cmd_y    = 9'd0;
        repeat (3) @(negedge clk);

        check("rst_we",       int'(bif.we), 0);
        check("rst_done",     int'(bif.done), 0);
        check("rst_busy",     int'(bif.busy), 0);
        check("rst_waddr",    int'(bif.waddr), 0);
        check("rst_wdata",    int'(bif.wdata), 0);
        check("rst_rom_addr", int'(bif.rom_addr), 0);

        // 3x2 image accepted in the very first cycle out of reset
        rst_n = 1'b1;
        clr();
        issue(OP_ADD, 1, 10, 5, t0, ra);
        check("img_rom_addr_t1", ra, 0);
        check("img_busy_t1", int'(bif.busy), 1);
        wait_done();
        ea = '{3210, 3211, 3212, 3850, 3851, 3852};
        ed = '{1, 2, 3, 4, 5, 6};
        chk_run("img", t0, 6, ea, ed, 5, 11);

        // transparent pixel 3 skipped
        img1[4] = 9'h088;
        clr();
        issue(OP_ADD, 1, 10, 5, t0, ra);
        wait_done();
        ea = '{3210, 3211, 3850, 3851, 3852, 0};
        ed = '{1, 2, 4, 5, 6, 0};
        chk_run("transp", t0, 5, ea, ed, 5, 11);
        img1[4] = 9'd3;

        // bottom-right corner: everything but pixel (0,0) clipped
        clr();
        issue(OP_ADD, 1, 639, 479, t0, ra);
        wait_done();
        ea = '{307199, 0, 0, 0, 0, 0};
        ed = '{1, 0, 0, 0, 0, 0};
        chk_run("clip", t0, 1, ea, ed, 5, 11);

        // glyph 2 at origin: 13x16 from the font sheet
        clr();
        issue(OP_GLYPH, 2, 0, 0, t0, ra);
        check("glyph_rom_addr_t1", ra, 26);
        wait_done();
        check("glyph_nwr", wq_addr.size(), 208);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 13; c++) begin
                if (r * 13 + c < wq_addr.size()) begin
                    check($sformatf("glyph_addr_r%0d_c%0d", r, c), wq_addr[r*13+c], r * 640 + c);
                    check($sformatf("glyph_data_r%0d_c%0d", r, c), wq_data[r*13+c],
                          int'(font_pix(16'(r * 546 + 26 + c))));
                end
            end
        end
        if (wq_cyc.size() > 0) check("glyph_first_we", wq_cyc[0], t0 + 3);
        check("glyph_ndone", dq.size(), 1);
        if (dq.size() > 0) check("glyph_done_cyc", dq[0], t0 + 211);

        // remove writes zeros at the same positions
        clr();
        issue(OP_REM, 1, 10, 5, t0, ra);
        wait_done();
        ea = '{3210, 3211, 3212, 3850, 3851, 3852};
        ed = '{0, 0, 0, 0, 0, 0};
        chk_run("remove", t0, 6, ea, ed, 5, 11);

        // zero-width image (index 0 reads all zeros)
        clr();
        issue(OP_ADD, 0, 10, 5, t0, ra);
        wait_done();
        chk_run("zero", t0, 0, ea, ed, 0, 4);

        // index 33 aliases ROM 1 but is out of range
        clr();
        issue(OP_ADD, 33, 10, 5, t0, ra);
        wait_done();
        chk_run("badidx", t0, 0, ea, ed, 0, 4);

        // reserved op
        clr();
        issue(OP_RSVD, 1, 10, 5, t0, ra);
        wait_done();
        chk_run("rsvd", t0, 0, ea, ed, 0, 1);

        // reset in the middle of a draw, then a normal command
        clr();
        issue(OP_ADD, 1, 10, 5, t0, ra);
        repeat (5) @(negedge clk);
        check("midrst_we_before", int'(bif.we), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_we",       int'(bif.we), 0);
        check("midrst_busy",     int'(bif.busy), 0);
        check("midrst_rom_addr", int'(bif.rom_addr), 0);
        check("midrst_waddr",    int'(bif.waddr), 0);
        repeat (3) @(negedge clk);
        check("midrst_no_done", dq.size(), 0);
        rst_n = 1'b1;
        clr();
        issue(OP_ADD, 1, 10, 5, t0, ra);
        wait_done();
        ea = '{3210, 3211, 3212, 3850, 3851, 3852};
        ed = '{1, 2, 3, 4, 5, 6};
        chk_run("after_rst", t0, 6, ea, ed, 5, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
